// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding.
package button_event_decoder_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StWait2  = 3'd2,
    StPress2 = 3'd3,
    StHeld   = 3'd4
  } state_e;

endpackage

// File: rtl/interval_timer.sv
// Tick-driven interval counter with synchronous clear and saturation.
// hit_o flags the tick that completes limit_i ticks since the last clear.
module interval_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit means the interval is disabled and never hits.
  assign hit_o = tick_i & (limit_i != '0) & (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into one-cycle press/release/click/long/repeat strobes.
// All timing is counted in tick_i strobes; every output is registered.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned LONG_TICKS   = 8,
  parameter int unsigned DCLICK_TICKS = 4,
  parameter int unsigned REPEAT_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o,
  output logic release_o,
  output logic single_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LongLim   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DclickLim = CNT_W'(DCLICK_TICKS);
  localparam logic [CNT_W-1:0] RepeatLim = CNT_W'(REPEAT_TICKS);

  state_e state_q, state_d;
  logic   btn_q;
  logic   rise, fall;
  logic   hit, clr;
  logic [CNT_W-1:0] limit;

  logic   single_d, double_d, long_d, repeat_d;
  logic   press_q, release_q, single_q, double_q, long_q, repeat_q, busy_q;

  assign rise = btn_i & ~btn_q;
  assign fall = ~btn_i & btn_q;

  // Interval length depends only on the current state; kept apart from the
  // next-state logic so the hit -> state_d path stays acyclic.
  always_comb begin
    limit = '0;
    unique case (state_q)
      StPress1, StPress2: limit = LongLim;
      StWait2:            limit = DclickLim;
      StHeld:             limit = RepeatLim;
      default:            limit = '0;
    endcase
  end

  // Edges are checked before hit so an edge coinciding with a tick wins.
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall) begin
          if (DCLICK_TICKS == 0) begin
            single_d = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait2;
          end
        end else if (hit) begin
          long_d  = 1'b1;
          state_d = StHeld;
        end
      end
      StWait2: begin
        if (rise) begin
          state_d = StPress2;
        end else if (hit) begin
          single_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StPress2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = StIdle;
        end else if (hit) begin
          long_d  = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (fall) begin
          state_d = StIdle;
        end else if (hit) begin
          repeat_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every hit either changes state or restarts the repeat period.
  assign clr = rise | fall | hit | (state_d != state_q);

  interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .tick_i  (tick_i),
    .limit_i (limit),
    .hit_o   (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_i;
      press_q   <= rise;
      release_q <= fall;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign single_o  = single_q;
  assign double_o  = double_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed table, corner sequences and random stimulus
// against a gesture-level reference model, on a default and a no-dclick/no-repeat instance.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_i = 1'b0;
  logic btn_i = 1'b0;

  logic press_o, release_o, single_o, double_o, long_o, repeat_o, busy_o;
  logic press_z, release_z, single_z, double_z, long_z, repeat_z, busy_z;

  always #5 clk = ~clk;

  button_event_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_i),
    .btn_i     (btn_i),
    .press_o   (press_o),
    .release_o (release_o),
    .single_o  (single_o),
    .double_o  (double_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o),
    .busy_o    (busy_o)
  );

  button_event_decoder #(
    .CNT_W        (24),
    .LONG_TICKS   (8),
    .DCLICK_TICKS (0),
    .REPEAT_TICKS (0)
  ) dut_z (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_i),
    .btn_i     (btn_i),
    .press_o   (press_z),
    .release_o (release_z),
    .single_o  (single_z),
    .double_o  (double_z),
    .long_o    (long_z),
    .repeat_o  (repeat_z),
    .busy_o    (busy_z)
  );

  // Strobe count indices
  localparam int IP = 0, IR = 1, IS = 2, ID = 3, IL = 4, IRP = 5;

  typedef struct {
    bit prev;     // last sampled button level
    bit active;   // a gesture is in progress
    int clicks;   // presses seen in this gesture
    bit is_long;  // the current hold already produced long
    int ticks;    // ticks since the last edge or timed event
  } mdl_t;

  typedef struct {
    bit         btn;
    bit         tick;
    logic [6:0] exp;  // {press, release, single, double, long, repeat, busy}
  } vec_t;

  mdl_t ma, mz;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cnt_a[6];
  int   cnt_z[6];
  vec_t tbl[9];

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.prev = 1'b0;
    m.active = 1'b0;
    m.clicks = 0;
    m.is_long = 1'b0;
    m.ticks = 0;
    return m;
  endfunction

  // Gesture-level reference: one call per clock, returns the outputs expected after the edge.
  task automatic model_step(inout mdl_t m, input bit btn, input bit tk, input int lng,
                            input int dck, input int rep, output logic [6:0] e);
    bit rise, fall, sgl, dbl, lg, rp;
    rise = btn & !m.prev;
    fall = !btn & m.prev;
    sgl = 0; dbl = 0; lg = 0; rp = 0;
    m.prev = btn;
    if (rise) begin
      if (!m.active) begin
        m.active = 1'b1;
        m.clicks = 1;
        m.is_long = 1'b0;
      end else begin
        m.clicks = 2;
      end
      m.ticks = 0;
    end else if (fall) begin
      if (m.active) begin
        if (m.is_long) begin
          m.active = 1'b0;
        end else if (m.clicks == 2) begin
          dbl = 1'b1;
          m.active = 1'b0;
        end else if (dck == 0) begin
          sgl = 1'b1;
          m.active = 1'b0;
        end
      end
      m.ticks = 0;
    end else if (tk && m.active) begin
      m.ticks++;
      if (btn && !m.is_long && m.ticks == lng) begin
        lg = 1'b1;
        m.is_long = 1'b1;
        m.ticks = 0;
      end else if (btn && m.is_long && rep != 0 && m.ticks == rep) begin
        rp = 1'b1;
        m.ticks = 0;
      end else if (!btn && m.ticks == dck) begin
        sgl = 1'b1;
        m.active = 1'b0;
      end
    end
    e = {rise, fall, sgl, dbl, lg, rp, m.active};
  endtask

  function automatic logic [6:0] outs_a();
    return {press_o, release_o, single_o, double_o, long_o, repeat_o, busy_o};
  endfunction

  function automatic logic [6:0] outs_z();
    return {press_z, release_z, single_z, double_z, long_z, repeat_z, busy_z};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 6; i++) begin
      cnt_a[i] = 0;
      cnt_z[i] = 0;
    end
  endtask

  task automatic step(input bit btn, input bit tk);
    logic [6:0] ea, ez, va, vz;
    @(negedge clk);
    btn_i = btn;
    tick_i = tk;
    model_step(ma, btn, tk, 8, 4, 3, ea);
    model_step(mz, btn, tk, 8, 0, 0, ez);
    @(posedge clk);
    #1;
    va = outs_a();
    vz = outs_z();
    check("model_dflt", va, ea);
    check("model_zero", vz, ez);
    for (int i = 0; i < 6; i++) begin
      if (va[6-i] === 1'b1) cnt_a[i]++;
      if (vz[6-i] === 1'b1) cnt_z[i]++;
    end
  endtask

  // Reset asserted at a negedge (outputs must clear at once), released just after a posedge.
  task automatic do_reset(input bit btn);
    @(negedge clk);
    btn_i = btn;
    tick_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_dflt", outs_a(), 7'b0);
    check("reset_zero", outs_z(), 7'b0);
    ma = mdl_init();
    mz = mdl_init();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_quiet", outs_a(), 7'b0);
  endtask

  initial begin
    bit b;
    bit t;

    // Short click: press 3 cycles, release, single 4 ticks later with busy dropping.
    tbl[0] = '{1'b1, 1'b1, 7'b1000001};
    tbl[1] = '{1'b1, 1'b1, 7'b0000001};
    tbl[2] = '{1'b1, 1'b1, 7'b0000001};
    tbl[3] = '{1'b0, 1'b1, 7'b0100001};
    tbl[4] = '{1'b0, 1'b1, 7'b0000001};
    tbl[5] = '{1'b0, 1'b1, 7'b0000001};
    tbl[6] = '{1'b0, 1'b1, 7'b0000001};
    tbl[7] = '{1'b0, 1'b1, 7'b0010000};
    tbl[8] = '{1'b0, 1'b1, 7'b0000000};

    ma = mdl_init();
    mz = mdl_init();
    clr_counts();
    do_reset(1'b0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].btn, tbl[i].tick);
      check($sformatf("tbl[%0d]", i), outs_a(), tbl[i].exp);
    end

    // Long hold of 20 ticks: one long, four repeats, no click on release.
    clr_counts();
    step(1, 1);
    repeat (20) step(1, 1);
    step(0, 1);
    repeat (6) step(0, 1);
    check_int("hold_long", cnt_a[IL], 1);
    check_int("hold_repeat", cnt_a[IRP], 4);
    check_int("hold_single", cnt_a[IS], 0);
    check_int("hold_double", cnt_a[ID], 0);

    // Double click with second press at tick 2 of the window.
    clr_counts();
    step(1, 1); step(1, 1); step(0, 1);
    step(0, 1); step(1, 1); step(1, 1); step(0, 1);
    repeat (6) step(0, 1);
    check_int("dbl_double", cnt_a[ID], 1);
    check_int("dbl_single", cnt_a[IS], 0);
    check_int("dbl_press", cnt_a[IP], 2);
    check_int("dbl_release", cnt_a[IR], 2);

    // Second press held into long: no double; zero-repeat instance never repeats.
    clr_counts();
    step(1, 1); step(1, 1); step(0, 1);
    step(1, 1);
    repeat (8) step(1, 1);
    check_int("p2_long_at_8", cnt_a[IL], 1);
    repeat (10) step(1, 1);
    step(0, 1);
    repeat (6) step(0, 1);
    check_int("p2_double", cnt_a[ID], 0);
    check_int("p2_long_total", cnt_a[IL], 1);
    check_int("z_long", cnt_z[IL], 1);
    check_int("z_repeat", cnt_z[IRP], 0);
    check_int("z_single", cnt_z[IS], 1);

    // Frozen timebase, then eighth tick; then press coinciding with a tick.
    clr_counts();
    step(1, 0);
    repeat (50) step(1, 0);
    check_int("frozen_long", cnt_a[IL], 0);
    repeat (7) step(1, 1);
    check_int("tick7_long", cnt_a[IL], 0);
    step(1, 1);
    check_int("tick8_long", cnt_a[IL], 1);
    step(0, 1);
    repeat (4) step(0, 1);
    clr_counts();
    step(1, 1);
    repeat (7) step(1, 1);
    check_int("coinc_tick7", cnt_a[IL], 0);
    step(1, 1);
    check_int("coinc_tick8", cnt_a[IL], 1);
    step(0, 1);
    repeat (4) step(0, 1);

    // Reset while waiting for a second press discards the pending single.
    step(1, 1); step(0, 1); step(0, 1);
    check("wait2_busy", {6'b0, busy_o}, 7'b0000001);
    clr_counts();
    do_reset(1'b0);
    repeat (8) step(0, 1);
    check_int("rst_single", cnt_a[IS], 0);

    // Button held through reset: press appears after the first edge.
    do_reset(1'b1);
    step(1, 1);
    check("held_rst_press", {press_o, 6'b0}, 7'b1000000);
    step(0, 1);
    repeat (6) step(0, 1);

    // Random stimulus against the model.
    b = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) b = !b;
      t = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) do_reset(b);
      step(b, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
